// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: byte-wide instruction fetch into a small FIFO, emitting little-endian 16-bit words over valid/ready
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              imem_addr,
  input  logic [7:0]               imem_data,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [15:0]              instr,
  output logic [15:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [15:0]   fetch_pc, head_pc;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          pop, push;
  assign instr_valid = count >= CW'(2);
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  // a pop frees two slots, so a full FIFO can still accept a byte in the same cycle
  assign push        = ~redirect_valid & ~halt & ((count < CW'(DEPTH)) | pop);
  assign imem_addr   = fetch_pc;
  assign instr_pc    = head_pc;
  assign fifo_level  = count;
  assign instr       = {mem[rd_ptr + AW'(1)], mem[rd_ptr]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 16'd1;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        head_pc <= head_pc + 16'd2;
        rd_ptr  <= rd_ptr + AW'(2);
      end
      count <= count + CW'(push) - (pop ? CW'(2) : CW'(0));
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= imem_data;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: table vectors, corner sequences and a randomized run against a byte-queue model
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 1;
  logic [15:0] imem_addr, redirect_pc = 0, instr, instr_pc;
  logic [7:0]  imem_data;
  logic        halt = 0, redirect_valid = 0, instr_valid, instr_ready = 0;
  logic [2:0]  fifo_level;
  logic [7:0]  rom [65536];
  int checks = 0, errors = 0;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fifo_level(fifo_level));

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  typedef struct {
    logic hlt; logic rd; logic [15:0] rpc; logic rdy;
    logic v; logic [15:0] ins; logic [15:0] pc; logic [2:0] lvl; logic [15:0] addr;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic [2:0] lvl, input logic [15:0] addr);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".level"}, 32'(fifo_level), 32'(lvl));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    if (v) begin
      chk({tag, ".instr"}, 32'(instr), 32'(ins));
      chk({tag, ".pc"}, 32'(instr_pc), 32'(pc));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1;
    #1 rst = 0;
  endtask

  logic [7:0]  q [$];
  logic [15:0] m_fetch, m_head;

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 8'(a) ^ 8'hA5;
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    //          hlt rd  rpc       rdy  v  instr     pc        lvl addr
    tbl[0]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 16'h0000};
    tbl[1]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0001};
    tbl[2]  = '{0, 0, 16'h0000, 1,   1, 16'h3412, 16'h0000, 2, 16'h0002};
    tbl[3]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0003};
    tbl[4]  = '{0, 0, 16'h0000, 0,   1, 16'h7856, 16'h0002, 2, 16'h0004};
    tbl[5]  = '{0, 0, 16'h0000, 0,   1, 16'h7856, 16'h0002, 3, 16'h0005};
    tbl[6]  = '{0, 0, 16'h0000, 0,   1, 16'h7856, 16'h0002, 4, 16'h0006};
    tbl[7]  = '{0, 0, 16'h0000, 1,   1, 16'h7856, 16'h0002, 4, 16'h0006};
    tbl[8]  = '{0, 1, 16'h0101, 1,   1, 16'hA0A1, 16'h0004, 3, 16'h0007};
    tbl[9]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 16'h0101};
    tbl[10] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0102};
    tbl[11] = '{0, 1, 16'hFFFF, 0,   1, 16'hA7A4, 16'h0101, 2, 16'h0103};
    tbl[12] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 16'hFFFF};
    tbl[13] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0000};
    tbl[14] = '{0, 0, 16'h0000, 1,   1, 16'h125A, 16'hFFFF, 2, 16'h0001};
    tbl[15] = '{1, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0002};
    tbl[16] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 1, 16'h0002};
    tbl[17] = '{0, 0, 16'h0000, 1,   1, 16'h5634, 16'h0001, 2, 16'h0003};
    #1 chk_out("reset", 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      halt = tbl[i].hlt; redirect_valid = tbl[i].rd; redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rdy;
      #1 chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].lvl, tbl[i].addr);
      cyc();
    end
    halt = 0; redirect_valid = 0; instr_ready = 0;
    // halt with three bytes buffered: one word drains, the lone byte waits
    pulse_rst();
    repeat (3) cyc();
    chk_out("halt.pre", 1, 16'h3412, 16'h0000, 3, 16'h0003);
    halt = 1; instr_ready = 1;
    cyc();
    #1 chk_out("halt.drain", 0, 0, 0, 1, 16'h0003);
    cyc();
    #1 chk_out("halt.hold", 0, 0, 0, 1, 16'h0003);
    halt = 0;
    cyc();
    #1 chk_out("halt.resume", 1, 16'h7856, 16'h0002, 2, 16'h0004);
    // asynchronous reset between edges with a full FIFO
    instr_ready = 0;
    pulse_rst();
    repeat (5) cyc();
    chk_out("arst.full", 1, 16'h3412, 16'h0000, 4, 16'h0004);
    #2 rst = 1;
    #1 chk_out("arst.now", 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    rst = 0; instr_ready = 1;
    repeat (2) cyc();
    #1 chk_out("arst.after", 1, 16'h3412, 16'h0000, 2, 16'h0002);
    // randomized run against a byte-queue model
    for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
    pulse_rst();
    q.delete(); m_fetch = 0; m_head = 0;
    for (int n = 0; n < 3000; n++) begin
      bit do_pop, do_push;
      halt = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      instr_ready = $urandom_range(0, 2) != 0;
      #1 chk_out("rand", q.size() >= 2, {q.size() >= 2 ? q[1] : 8'h0, q.size() >= 2 ? q[0] : 8'h0},
                 m_head, 3'(q.size()), m_fetch);
      if (redirect_valid) begin
        q.delete(); m_fetch = redirect_pc; m_head = redirect_pc;
      end else begin
        do_pop = instr_ready && q.size() >= 2;
        do_push = !halt && (q.size() < DEPTH || do_pop);
        if (do_pop) begin
          void'(q.pop_front()); void'(q.pop_front()); m_head += 16'd2;
        end
        if (do_push) begin
          q.push_back(rom[m_fetch]); m_fetch += 16'd1;
        end
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction-fetch front end for the TMEPT CPU. It drives the instruction-bus address of the 64 KB asynchronous-read instruction ROM and captures one byte per cycle into a small prefetch FIFO. It assembles little-endian 16-bit instruction words and presents them to the decoder over a valid/ready handshake. A redirect port lets branches and jumps flush the FIFO and restart fetch at any byte address.

Parameters:
DEPTH, 4, FIFO capacity in bytes; must be a power of two and at least 2.
RESET_PC, 16'h0000, fetch address loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_addr  output  16  byte address to the instruction ROM; combinational from fetch_pc register.
imem_data  input  8  ROM read data; valid in the same cycle as imem_addr.
halt  input  1  when 1, suppress new FIFO pushes; the FIFO still drains.
redirect_valid  input  1  flush request.
redirect_pc  input  16  new fetch address; any value, odd allowed.
instr_valid  output  1  instr and instr_pc hold a complete word.
instr_ready  input  1  consumer accepts the word.
instr  output  16  {byte[head+1], byte[head]}.
instr_pc  output  16  address of the low byte of instr.
fifo_level  output  $clog2(DEPTH)+1  current byte count.

Behaviour:
- Reset is async, active-high, and may assert mid-operation:
  - fetch_pc = head_pc = RESET_PC; count = 0.
  - FIFO pointers = 0.
  - instr_valid = 0, fifo_level = 0, imem_addr = RESET_PC.
  - instr and instr_pc are don't-care while instr_valid = 0.
- pop = instr_valid & instr_ready & !redirect_valid.
- push = !redirect_valid & !halt & (count < DEPTH | pop).
  - On push: store imem_data at the tail, and fetch_pc <= fetch_pc + 1 (mod 2^16; 16'hFFFF wraps to 16'h0000).
- On pop:
  - Remove 2 bytes.
  - head_pc <= head_pc + 2 (mod 2^16).
- count update per edge:
  - count + push - 2*pop.
  - Never exceeds DEPTH; never goes below 0.
- instr_valid = (count >= 2); this is a registered-state decode, with no combinational path from instr_ready.
- instr_pc = head_pc.
- instr is read combinationally from the FIFO head; the FIFO read pointer wraps modulo DEPTH.
- Redirect, when redirect_valid = 1 at an edge:
  - count <= 0, pointers reset.
  - fetch_pc <= redirect_pc, head_pc <= redirect_pc.
  - No push and no pop that cycle; a word shown with instr_ready = 1 is discarded and not consumed.
- Redirect has priority over halt, push and pop.
- Back-to-back redirects: the last one wins.
- Latency:
  - After reset release or a redirect, the first word is valid 2 edges later (one byte per edge), assuming halt = 0.
  - Steady state: one byte per cycle in, so at most one word every 2 cycles out.
- Full FIFO with no pop: imem_addr holds; no push.
- Full FIFO with a pop: the push still occurs in the same cycle.
- halt = 1:
  - imem_addr holds.
  - Existing complete words still drain.
  - A lone byte (count = 1) stays until halt drops.
- Word straddling 16'hFFFF/16'h0000: instr = {mem[0x0000], mem[0xFFFF]}, instr_pc = 16'hFFFF.
- Odd redirect_pc: words are assembled from odd alignment; there is no alignment fault.
- imem_data is sampled only on push edges; a ROM with no initialised data reads as 0x00, which is a harmless instruction.

Test Plan:
1. ROM[0x0000]=0x12, ROM[0x0001]=0x34, ROM[0x0002]=0x56, ROM[0x0003]=0x78. Release reset, hold instr_ready = 1 -> instr_valid rises after 2nd edge with instr=16'h3412, instr_pc=16'h0000; next word 16'h7856 at instr_pc=16'h0002 two cycles later.
2. Hold instr_ready = 0 from reset with DEPTH = 4 -> fifo_level reaches 4, imem_addr stalls at 16'h0004, instr stays 16'h3412. Raise instr_ready -> pushes resume in the same cycle as the first pop; fifo_level reads 3.
3. Mid-stream, pulse redirect_valid with redirect_pc=16'h0101 while instr_ready = 1 -> the word at the head is not consumed, fifo_level = 0 next cycle, and the next word is {ROM[0x0102], ROM[0x0101]} at instr_pc 16'h0101.
4. Redirect to 16'hFFFF -> first instr={ROM[0x0000], ROM[0xFFFF]} with instr_pc=16'hFFFF; next word has instr_pc=16'h0001; imem_addr wraps to 16'h0000.
5. With halt = 1 and fifo_level = 3 -> one word drains, a lone byte remains, instr_valid = 0, imem_addr is unchanged; drop halt -> the word completes on the next edge.
6. Assert rst asynchronously between edges while fifo_level = 4 -> instr_valid, fifo_level and imem_addr read 0/0/RESET_PC immediately; normal fetch resumes after release.
